fft_addr_gen: RTL and testbench

//  In-place address/control generator for the iterative radix-2 DIT FFT core.
//  Per butterfly, one cycle each: issues RAM read address pair, twiddle ROM address and valid.

---
 rtl/fft_addr_gen_pkg.sv | 23 ++
 rtl/fft_addr_gen_map.sv | 34 +++
 rtl/fft_addr_gen.sv | 137 +++++++++++++
 tb/tb_fft_addr_gen.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_addr_gen_pkg.sv
// Shared definitions for the in-place radix-2 DIT FFT address generator.
package fft_addr_gen_pkg;

    localparam int unsigned DEF_ADDR_W = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_t;

    // Ceiling log2, never less than 1 so it can size a port directly.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fft_addr_gen_map.sv
// Butterfly address map: stage s, butterfly b -> read pair (A, B) and twiddle index.
module fft_addr_gen_map
    import fft_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    localparam int unsigned SW = clog2(ADDR_W)
) (
    input  logic [SW-1:0]     stage,
    input  logic [ADDR_W-2:0] bfly,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [ADDR_W-2:0] tw_addr
);

    localparam int unsigned BW = ADDR_W - 1;

    logic [BW-1:0]     mask;
    logic [BW-1:0]     j;
    logic [BW-1:0]     g;
    logic [ADDR_W-1:0] a;
    logic [SW-1:0]     tw_sh;

    // At the final stage 1<<s overflows BW bits to 0, so the mask wraps to all ones.
    assign mask    = (BW'(1) << stage) - BW'(1);
    assign j       = bfly & mask;
    assign g       = bfly >> stage;
    assign a       = ((ADDR_W'(g) << stage) << 1) | ADDR_W'(j);
    assign tw_sh   = SW'(ADDR_W - 1) - stage;

    assign addr_a  = a;
    assign addr_b  = a | (ADDR_W'(1) << stage);
    assign tw_addr = j << tw_sh;

endmodule

// File: rtl/fft_addr_gen.sv
// In-place address/control generator for the iterative radix-2 DIT FFT core.
// One butterfly per enabled cycle, PIPE_DLY idle cycles after each stage for write-back.
module fft_addr_gen
    import fft_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned PIPE_DLY = 3,
    localparam int unsigned SW = clog2(ADDR_W)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              i_START,
    output logic [ADDR_W-1:0] o_ADDR_A,
    output logic [ADDR_W-1:0] o_ADDR_B,
    output logic [ADDR_W-2:0] o_TW_ADDR,
    output logic [SW-1:0]     o_STAGE,
    output logic              o_VALID,
    output logic              o_LAST,
    output logic              o_BUSY,
    output logic              o_DONE
);

    localparam int unsigned   BW     = ADDR_W - 1;
    localparam int unsigned   DW     = clog2(PIPE_DLY + 1);
    localparam logic [BW-1:0] LAST_B = '1;
    localparam logic [SW-1:0] LAST_S = SW'(ADDR_W - 1);
    localparam logic [DW-1:0] LAST_D = DW'((PIPE_DLY > 0) ? PIPE_DLY - 1 : 0);

    state_t        state_q, state_d;
    logic [BW-1:0] b_q, b_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [DW-1:0] drain_q, drain_d;

    logic              valid_d, last_d, done_d, busy_d;
    logic [ADDR_W-1:0] map_a, map_b;
    logic [ADDR_W-2:0] map_tw;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            b_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
        end else if (EN) begin
            state_q <= state_d;
            b_q     <= b_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        stage_d = stage_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (i_START) begin
                    state_d = StRun;
                    b_d     = '0;
                    stage_d = '0;
                end
            end
            StRun: begin
                if (b_q != LAST_B) begin
                    b_d = b_q + 1'b1;
                end else if (PIPE_DLY > 0) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else if (stage_q == LAST_S) begin
                    state_d = StDone;
                end else begin
                    stage_d = stage_q + 1'b1;
                    b_d     = '0;
                end
            end
            StDrain: begin
                if (drain_q != LAST_D) begin
                    drain_d = drain_q + 1'b1;
                end else if (stage_q == LAST_S) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                    stage_d = stage_q + 1'b1;
                    b_d     = '0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Addresses are computed from next-state counters so the outputs can be registered.
    fft_addr_gen_map #(
        .ADDR_W(ADDR_W)
    ) u_map (
        .stage  (stage_d),
        .bfly   (b_d),
        .addr_a (map_a),
        .addr_b (map_b),
        .tw_addr(map_tw)
    );

    always_comb begin
        valid_d = (state_d == StRun);
        last_d  = valid_d && (b_d == LAST_B);
        done_d  = (state_d == StDone);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_VALID   <= 1'b0;
            o_LAST    <= 1'b0;
            o_DONE    <= 1'b0;
            o_BUSY    <= 1'b0;
            o_ADDR_A  <= '0;
            o_ADDR_B  <= '0;
            o_TW_ADDR <= '0;
            o_STAGE   <= '0;
        end else if (EN) begin
            o_VALID <= valid_d;
            o_LAST  <= last_d;
            o_DONE  <= done_d;
            o_BUSY  <= busy_d;
            if (valid_d) begin
                o_ADDR_A  <= map_a;
                o_ADDR_B  <= map_b;
                o_TW_ADDR <= map_tw;
                o_STAGE   <= stage_d;
            end
        end
    end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Self-checking bench for fft_addr_gen: small transforms against fixed tables, N=1024 by model.
module tb_fft_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en0, st0, en1, st1, en2, st2;

    logic [2:0] a0, b0;
    logic [1:0] tw0, sg0;
    logic       v0, l0, bz0, dn0;
    logic [2:0] a1, b1;
    logic [1:0] tw1, sg1;
    logic       v1, l1, bz1, dn1;
    logic [9:0] a2, b2;
    logic [8:0] tw2;
    logic [3:0] sg2;
    logic       v2, l2, bz2, dn2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int a;
        int b;
        int tw;
        int s;
    } bf_t;

    bf_t sb[$];

    localparam int EXP_A  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    localparam int EXP_B  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    localparam int EXP_TW [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fft_addr_gen #(.ADDR_W(3), .PIPE_DLY(3)) u_dut0 (
        .CLK(clk), .RST(rst), .EN(en0), .i_START(st0),
        .o_ADDR_A(a0), .o_ADDR_B(b0), .o_TW_ADDR(tw0), .o_STAGE(sg0),
        .o_VALID(v0), .o_LAST(l0), .o_BUSY(bz0), .o_DONE(dn0)
    );

    fft_addr_gen #(.ADDR_W(3), .PIPE_DLY(0)) u_dut1 (
        .CLK(clk), .RST(rst), .EN(en1), .i_START(st1),
        .o_ADDR_A(a1), .o_ADDR_B(b1), .o_TW_ADDR(tw1), .o_STAGE(sg1),
        .o_VALID(v1), .o_LAST(l1), .o_BUSY(bz1), .o_DONE(dn1)
    );

    fft_addr_gen #(.ADDR_W(10), .PIPE_DLY(3)) u_dut2 (
        .CLK(clk), .RST(rst), .EN(en2), .i_START(st2),
        .o_ADDR_A(a2), .o_ADDR_B(b2), .o_TW_ADDR(tw2), .o_STAGE(sg2),
        .o_VALID(v2), .o_LAST(l2), .o_BUSY(bz2), .o_DONE(dn2)
    );

    task automatic push_small();
        sb.delete();
        for (int i = 0; i < 12; i++) sb.push_back(bf_t'{EXP_A[i], EXP_B[i], EXP_TW[i], i / 4});
    endtask

    // Full ADDR_W=3/PIPE_DLY=3 transform on dut0; e counts enabled edges since the start edge.
    task automatic run_seq0(input string name, input int stall_at, input int stall_len,
                            input bit poke);
        bf_t cur;
        int  e, c, st_left, done_c;
        bit  fresh, st_done, exp_v, exp_l, seen_v;
        push_small();
        cur = bf_t'{0, 0, 0, 0};
        seen_v = 1'b0;
        e = 1; c = 1; st_left = 0; done_c = 0; fresh = 1'b1; st_done = 1'b0;
        @(negedge clk); en0 = 1'b1; st0 = 1'b1;
        @(negedge clk); st0 = 1'b0;
        while (e <= 23 && c <= 80) begin
            exp_v = (e <= 21) && ((e - 1) % 7 < 4);
            exp_l = exp_v && ((e - 1) % 7 == 3);
            if (fresh && exp_v) begin
                cur = sb.pop_front();
                seen_v = 1'b1;
            end
            n_cmp++;
            if ({v0, l0, dn0, bz0} !== {exp_v, exp_l, e == 22, e <= 22}) begin
                n_err++;
                $display("FAIL %s ctrl e%0d c%0d: got v%b l%b d%b b%b, want v%b l%b d%b b%b",
                         name, e, c, v0, l0, dn0, bz0, exp_v, exp_l, e == 22, e <= 22);
            end
            if (seen_v) begin
                n_cmp++;
                if ({a0, b0, tw0, sg0} !== {3'(cur.a), 3'(cur.b), 2'(cur.tw), 2'(cur.s)}) begin
                    n_err++;
                    $display("FAIL %s addr e%0d: got A%0d B%0d TW%0d S%0d, want A%0d B%0d TW%0d S%0d",
                             name, e, a0, b0, tw0, sg0, cur.a, cur.b, cur.tw, cur.s);
                end
            end
            if (dn0 && done_c == 0) done_c = c;
            st0 = poke && (e <= 20) && (e % 3 == 0);
            if (st_left > 0) begin
                en0 = 1'b0; st_left--; fresh = 1'b0;
            end else if (stall_len > 0 && e == stall_at && !st_done) begin
                en0 = 1'b0; st_left = stall_len - 1; st_done = 1'b1; fresh = 1'b0;
            end else begin
                en0 = 1'b1; e++; fresh = 1'b1;
            end
            @(negedge clk);
            c++;
        end
        en0 = 1'b1; st0 = 1'b0;
        n_cmp++;
        if (e <= 23) begin
            n_err++;
            $display("FAIL %s timeout: reached event %0d, want 24", name, e);
        end
        n_cmp++;
        if (done_c != 22 + stall_len) begin
            n_err++;
            $display("FAIL %s done_cycle: got %0d, want %0d", name, done_c, 22 + stall_len);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({v0, l0, dn0, bz0, a0, b0, tw0, sg0} !== 14'd0) begin
            n_err++;
            $display("FAIL reset dut0: got %h, want 0", {v0, l0, dn0, bz0, a0, b0, tw0, sg0});
        end
        n_cmp++;
        if ({v1, l1, dn1, bz1, a1, b1, tw1, sg1} !== 14'd0) begin
            n_err++;
            $display("FAIL reset dut1: got %h, want 0", {v1, l1, dn1, bz1, a1, b1, tw1, sg1});
        end
        n_cmp++;
        if ({v2, l2, dn2, bz2, a2, b2, tw2, sg2} !== 37'd0) begin
            n_err++;
            $display("FAIL reset dut2: got %h, want 0", {v2, l2, dn2, bz2, a2, b2, tw2, sg2});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_seq0("basic", 0, 0, 1'b0);
    endtask

    task automatic test_en_stall();
        run_seq0("en_stall", 9, 5, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_seq0("start_poke", 0, 0, 1'b1);
    endtask

    task automatic test_no_drain();
        bf_t cur;
        bit  exp_v, exp_l;
        push_small();
        cur = bf_t'{0, 0, 0, 0};
        @(negedge clk); st1 = 1'b1;
        @(negedge clk); st1 = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            exp_v = (c <= 12);
            exp_l = exp_v && (c % 4 == 0);
            if (exp_v) cur = sb.pop_front();
            n_cmp++;
            if ({v1, l1, dn1, bz1} !== {exp_v, exp_l, c == 13, c <= 13}) begin
                n_err++;
                $display("FAIL no_drain ctrl c%0d: got v%b l%b d%b b%b, want v%b l%b d%b b%b",
                         c, v1, l1, dn1, bz1, exp_v, exp_l, c == 13, c <= 13);
            end
            n_cmp++;
            if ({a1, b1, tw1, sg1} !== {3'(cur.a), 3'(cur.b), 2'(cur.tw), 2'(cur.s)}) begin
                n_err++;
                $display("FAIL no_drain addr c%0d: got A%0d B%0d TW%0d S%0d, want A%0d B%0d TW%0d S%0d",
                         c, a1, b1, tw1, sg1, cur.a, cur.b, cur.tw, cur.s);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_en0();
        @(negedge clk); en0 = 1'b0; st0 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 2) begin
                st0 = 1'b0; en0 = 1'b1;
            end
            n_cmp++;
            if ({v0, bz0, dn0} !== 3'b000) begin
                n_err++;
                $display("FAIL start_en0 idle %0d: got v%b b%b d%b, want 000", i, v0, bz0, dn0);
            end
        end
    endtask

    task automatic test_abort();
        @(negedge clk); en0 = 1'b1; st0 = 1'b1;
        @(negedge clk); st0 = 1'b0;
        repeat (11) @(negedge clk);
        n_cmp++;
        if ({v0, bz0, sg0} !== {1'b0, 1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL abort in_drain: got v%b b%b s%0d, want v0 b1 s1", v0, bz0, sg0);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({v0, l0, dn0, bz0, a0, b0, tw0, sg0} !== 14'd0) begin
            n_err++;
            $display("FAIL abort async_clear: got %h, want 0", {v0, l0, dn0, bz0, a0, b0, tw0, sg0});
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            n_cmp++;
            if ({dn0, bz0, v0} !== 3'b000) begin
                n_err++;
                $display("FAIL abort quiet %0d: got d%b b%b v%b, want 000", i, dn0, bz0, v0);
            end
            @(negedge clk);
        end
        run_seq0("after_abort", 0, 0, 1'b0);
    endtask

    task automatic test_large();
        bf_t            cur;
        logic [1023:0]  seen;
        int             nv, done_c, c, low;
        sb.delete();
        for (int s = 0; s < 10; s++) begin
            for (int b = 0; b < 512; b++) begin
                low = b & ((1 << s) - 1);
                sb.push_back(bf_t'{((b - low) << 1) | low, (((b - low) << 1) | low) + (1 << s),
                                   (low << (9 - s)) & 511, s});
            end
        end
        seen = '0; nv = 0; done_c = 0;
        @(negedge clk); st2 = 1'b1;
        @(negedge clk); st2 = 1'b0;
        c = 1;
        while (c <= 5300 && done_c == 0) begin
            if (v2) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL large extra_valid c%0d: got A%0d, want no valid", c, a2);
                end else begin
                    cur = sb.pop_front();
                    n_cmp++;
                    if ({a2, b2, tw2, sg2} !== {10'(cur.a), 10'(cur.b), 9'(cur.tw), 4'(cur.s)}) begin
                        n_err++;
                        $display("FAIL large addr c%0d: got A%0d B%0d TW%0d S%0d, want A%0d B%0d TW%0d S%0d",
                                 c, a2, b2, tw2, sg2, cur.a, cur.b, cur.tw, cur.s);
                    end
                end
                n_cmp++;
                if (seen[a2] || seen[b2]) begin
                    n_err++;
                    $display("FAIL large distinct c%0d: got repeat A%0d B%0d, want fresh", c, a2, b2);
                end
                seen[a2] = 1'b1;
                seen[b2] = 1'b1;
                nv++;
                n_cmp++;
                if (l2 !== (nv == 512)) begin
                    n_err++;
                    $display("FAIL large last c%0d: got %b, want %b", c, l2, nv == 512);
                end
                if (nv == 512) begin
                    n_cmp++;
                    if (!(&seen)) begin
                        n_err++;
                        $display("FAIL large coverage stage%0d: got incomplete, want 0..1023", sg2);
                    end
                    seen = '0;
                    nv = 0;
                end
            end
            if (dn2) done_c = c;
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (done_c != 5151) begin
            n_err++;
            $display("FAIL large done_cycle: got %0d, want 5151", done_c);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL large valid_count: got %0d short, want 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        en0 = 1'b1; st0 = 1'b0;
        en1 = 1'b1; st1 = 1'b0;
        en2 = 1'b1; st2 = 1'b0;
        test_reset();
        test_basic();
        test_no_drain();
        test_en_stall();
        test_start_ignored();
        test_start_en0();
        test_abort();
        test_large();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
